// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and slave FSM states (S_WAIT exists only with AHB_SLV_WAIT_EN)
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE,
        TRANS_BUSY,
        TRANS_NONSEQ,
        TRANS_SEQ
    } trans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE,
        BURST_INCR,
        BURST_WRAP4,
        BURST_INCR4,
        BURST_WRAP8,
        BURST_INCR8,
        BURST_WRAP16,
        BURST_INCR16
    } burst_e;

    typedef enum logic {
        RESP_OKAY,
        RESP_ERROR
    } resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
`ifdef AHB_SLV_WAIT_EN
        S_ERR2,
        S_WAIT
`else
        S_ERR2
`endif
    } slv_state_e;

    // Beats per wrapping burst; 0 marks a non-wrapping (linear) burst type.
    function automatic int unsigned wrap_beats(input logic [2:0] burst);
        case (burst)
            BURST_WRAP4:  return 4;
            BURST_WRAP8:  return 8;
            BURST_WRAP16: return 16;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_next_addr.sv
// rtl/ahb_burst_next_addr.sv - combinational next-beat address for AHB INCR and WRAP bursts
module ahb_burst_next_addr
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [2:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] linear;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // A zero beat count makes wrap_mask all ones, so linear bursts fall out of the same expression.
    always_comb begin
        linear    = addr + (ADDR_WIDTH'(1) << size);
        wrap_mask = (ADDR_WIDTH'(wrap_beats(burst)) << size) - ADDR_WIDTH'(1);
        next_addr = (addr & ~wrap_mask) | (linear & wrap_mask);
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB SRAM slave with burst checking; define AHB_SLV_WAIT_EN for WAIT_CYCLES wait states per beat
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = `AHB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = `AHB_DATA_WIDTH,
    parameter int                    MEM_DEPTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sel,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [1:0]              trans,
    input  logic                    write,
    input  logic [2:0]              size,
    input  logic [2:0]              burst,
    input  logic [3:0]              prot,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    ready_in,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready_out,
    output logic                    resp
);

    localparam int                    NBYTES   = DATA_WIDTH / 8;
    localparam int                    LANE_W   = $clog2(NBYTES);
    localparam int                    IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(MEM_DEPTH * NBYTES);
    localparam logic [2:0]            SIZE_MAX = 3'(LANE_W);
`ifdef AHB_SLV_WAIT_EN
    localparam int                    CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
`endif

    slv_state_e              state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    write_q, write_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NBYTES-1:0]       lanes_q, lanes_d;
    logic                    burst_act_q, burst_act_d;
    logic [ADDR_WIDTH-1:0]   exp_addr_q, exp_addr_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];
`ifdef AHB_SLV_WAIT_EN
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [IDX_W-1:0]        acc_idx;
    logic [NBYTES-1:0]       acc_lanes;
    logic                    accept;
    logic                    legal;
    logic                    commit;
    int                      lane_lo;
    int                      nb;
    logic                    unused_ok;

    ahb_burst_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_addr (
        .addr      (addr),
        .size      (size),
        .burst     (burst),
        .next_addr (next_addr)
    );

    always_comb begin
        offset  = addr - BASE_ADDR;
        accept  = sel && ready_in && trans[1];
        legal   = (addr >= BASE_ADDR) && (offset < SPAN)
               && (size <= SIZE_MAX)
               && ((addr & ((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1))) == '0)
               && ((trans != TRANS_SEQ) || (burst_act_q && (addr == exp_addr_q)));
        acc_idx = offset[LANE_W +: IDX_W];
        lane_lo = int'(offset & ADDR_WIDTH'(NBYTES - 1));
        nb      = 1 << size;
        for (int i = 0; i < NBYTES; i++) begin
            acc_lanes[i] = (i >= lane_lo) && (i < lane_lo + nb);
        end
    end

    // mem_d already holds the committing write, so reads taken from it are forwarded.
    assign commit = (state_q == S_DATA) && write_q;

    always_comb begin
        mem_d = mem_q;
        if (commit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (strb[i] && lanes_q[i]) begin
                    mem_d[idx_q][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b1;
        resp_d      = RESP_OKAY;
        rdata_d     = '0;
        write_d     = write_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        burst_act_d = burst_act_q;
        exp_addr_d  = exp_addr_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_ERR1: begin
                state_d = S_ERR2;
                resp_d  = RESP_ERROR;
            end
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    rdata_d = write_q ? '0 : mem_d[idx_q];
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    ready_d = 1'b0;
                end
            end
`endif
            default: begin
                if (!accept) begin
                    state_d = S_IDLE;
                end else if (!legal) begin
                    state_d     = S_ERR1;
                    ready_d     = 1'b0;
                    resp_d      = RESP_ERROR;
                    burst_act_d = 1'b0;
                end else begin
                    write_d     = write;
                    idx_d       = acc_idx;
                    lanes_d     = acc_lanes;
                    burst_act_d = (burst != BURST_SINGLE);
                    exp_addr_d  = next_addr;
`ifdef AHB_SLV_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        ready_d = 1'b0;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_DATA;
                        rdata_d = write ? '0 : mem_d[acc_idx];
                    end
`else
                    state_d = S_DATA;
                    rdata_d = write ? '0 : mem_d[acc_idx];
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            resp_q      <= RESP_OKAY;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            lanes_q     <= '0;
            burst_act_q <= 1'b0;
            exp_addr_q  <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt_q       <= '0;
`endif
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            lanes_q     <= lanes_d;
            burst_act_q <= burst_act_d;
            exp_addr_q  <= exp_addr_d;
`ifdef AHB_SLV_WAIT_EN
            cnt_q       <= cnt_d;
`endif
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata     = rdata_q;
    assign ready_out = ready_q;
    assign resp      = resp_q;

    // Protection attributes carry no meaning for a plain SRAM region.
    assign unused_ok = ^{prot, offset, WAIT_CYCLES[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [1:0]  NS   = 2'b10;
    localparam logic [1:0]  SQ   = 2'b11;
`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready_out;
    logic        resp;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] b_addr  [8];
    logic [1:0]  b_trans [8];
    logic        b_write [8];
    logic [2:0]  b_size  [8];
    logic [2:0]  b_burst [8];
    logic [31:0] b_wdata [8];
    logic [3:0]  b_strb  [8];
    int          b_wait  [8];
    logic        b_resp_lo [8];
    logic        b_resp  [8];
    logic        b_done  [8];
    logic [31:0] b_rdata [8];

    always #5 clk = ~clk;

    ahb_sram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (64),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sel       (sel),
        .addr      (addr),
        .trans     (trans),
        .write     (write),
        .size      (size),
        .burst     (burst),
        .prot      (prot),
        .strb      (strb),
        .wdata     (wdata),
        .ready_in  (ready_out),
        .rdata     (rdata),
        .ready_out (ready_out),
        .resp      (resp)
    );

    task automatic set_beat(input int i, input logic [31:0] off, input logic [1:0] t, input logic w,
                            input logic [2:0] s, input logic [2:0] b, input logic [31:0] d, input logic [3:0] st);
        b_addr[i]  = BASE + off;
        b_trans[i] = t;
        b_write[i] = w;
        b_size[i]  = s;
        b_burst[i] = b;
        b_wdata[i] = d;
        b_strb[i]  = st;
    endtask

    // Pipelined master: address of beat k overlaps the data phase of beat k-1; aborts after an ERROR.
    task automatic run_beats(input int n);
        int ap, dp, cyc;
        bit abort, act, fin;
        ap = 0; dp = -1; cyc = 0; abort = 0; fin = 0;
        for (int i = 0; i < n; i++) begin
            b_wait[i] = 0; b_resp_lo[i] = 0; b_resp[i] = 0; b_done[i] = 0; b_rdata[i] = '0;
        end
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dp >= 0) begin
                if (!ready_out) begin
                    b_wait[dp]++;
                    if (resp) begin
                        b_resp_lo[dp] = 1'b1;
                        abort = 1;
                    end
                end else begin
                    b_resp[dp]  = resp;
                    b_rdata[dp] = rdata;
                    b_done[dp]  = 1'b1;
                end
            end
            act = (ap < n) && !abort;
            if (act) begin
                sel = 1'b1; addr = b_addr[ap]; trans = b_trans[ap]; write = b_write[ap];
                size = b_size[ap]; burst = b_burst[ap];
            end else begin
                sel = 1'b0; addr = '0; trans = 2'b00; write = 1'b0; size = 3'd0; burst = 3'd0;
            end
            if (dp >= 0) begin
                wdata = b_wdata[dp]; strb = b_strb[dp];
            end else begin
                wdata = '0; strb = '0;
            end
            if (dp < 0 && !act) fin = 1;
            else if (ready_out) begin
                dp = act ? ap : -1;
                if (act) ap++;
            end
        end
        vectors++;
        if (!fin) begin
            $display("FAIL run_beats_timeout: finished=%0d required=1", fin);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; sel = 1'b0; addr = '0; trans = 2'b00; write = 1'b0;
        size = 3'd0; burst = 3'd0; prot = 4'h3; strb = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vectors++; if (ready_out !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", ready_out); miscompares++; end
        vectors++; if (resp !== 1'b0) begin $display("FAIL reset_resp: got %b want 0", resp); miscompares++; end
        vectors++; if (rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", rdata); miscompares++; end
        set_beat(0, 32'h0, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(1);
        vectors++; if (b_done[0] !== 1'b1 || b_rdata[0] !== 32'h0 || b_resp[0] !== 1'b0) begin
            $display("FAIL reset_read0: got done=%b rdata=%h resp=%b want 1 00000000 0", b_done[0], b_rdata[0], b_resp[0]);
            miscompares++;
        end
    endtask

    task automatic test_single();
        set_beat(0, 32'h10, NS, 1'b1, 3'd2, 3'd0, 32'hDEADBEEF, 4'hF);
        run_beats(1);
        vectors++; if (b_resp[0] !== 1'b0 || b_wait[0] != EXP_WAIT || b_rdata[0] !== 32'h0) begin
            $display("FAIL single_write: got resp=%b wait=%0d rdata=%h want 0 %0d 00000000", b_resp[0], b_wait[0], b_rdata[0], EXP_WAIT);
            miscompares++;
        end
        set_beat(0, 32'h10, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(1);
        vectors++; if (b_rdata[0] !== 32'hDEADBEEF || b_resp[0] !== 1'b0 || b_wait[0] != EXP_WAIT) begin
            $display("FAIL single_read: got rdata=%h resp=%b wait=%0d want deadbeef 0 %0d", b_rdata[0], b_resp[0], b_wait[0], EXP_WAIT);
            miscompares++;
        end
    endtask

    task automatic test_byte_write();
        set_beat(0, 32'h11, NS, 1'b1, 3'd0, 3'd0, 32'h0000AB00, 4'hF);
        set_beat(1, 32'h10, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(2);
        vectors++; if (b_rdata[1] !== 32'hDEADABEF || b_resp[0] !== 1'b0 || b_resp[1] !== 1'b0) begin
            $display("FAIL byte_write: got rdata=%h resp=%b%b want deadabef 00", b_rdata[1], b_resp[0], b_resp[1]);
            miscompares++;
        end
    endtask

    task automatic test_wrap4();
        logic [31:0] offs [4];
        logic [31:0] d    [4];
        logic [31:0] rexp [4];
        offs[0] = 32'h38; offs[1] = 32'h3C; offs[2] = 32'h30; offs[3] = 32'h34;
        d[0] = 32'hA0A0_0000; d[1] = 32'hA1A1_1111; d[2] = 32'hA2A2_2222; d[3] = 32'hA3A3_3333;
        for (int i = 0; i < 4; i++) set_beat(i, offs[i], (i == 0) ? NS : SQ, 1'b1, 3'd2, 3'd2, d[i], 4'hF);
        run_beats(4);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (b_done[i] !== 1'b1 || b_resp[i] !== 1'b0 || b_wait[i] != EXP_WAIT) begin
                $display("FAIL wrap4_beat%0d: got done=%b resp=%b wait=%0d want 1 0 %0d", i, b_done[i], b_resp[i], b_wait[i], EXP_WAIT);
                miscompares++;
            end
        end
        rexp[0] = d[2]; rexp[1] = d[3]; rexp[2] = d[0]; rexp[3] = d[1];
        for (int i = 0; i < 4; i++) set_beat(i, 32'h30 + 32'(4 * i), (i == 0) ? NS : SQ, 1'b0, 3'd2, 3'd3, 32'h0, 4'h0);
        run_beats(4);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (b_rdata[i] !== rexp[i] || b_resp[i] !== 1'b0) begin
                $display("FAIL incr4_read%0d: got rdata=%h resp=%b want %h 0", i, b_rdata[i], b_resp[i], rexp[i]);
                miscompares++;
            end
        end
        set_beat(0, 32'h38, NS, 1'b1, 3'd2, 3'd2, 32'hB0B0_0000, 4'hF);
        set_beat(1, 32'h3C, SQ, 1'b1, 3'd2, 3'd2, 32'hB1B1_1111, 4'hF);
        set_beat(2, 32'h30, SQ, 1'b1, 3'd2, 3'd2, 32'hB2B2_2222, 4'hF);
        set_beat(3, 32'h40, SQ, 1'b1, 3'd2, 3'd2, 32'hB3B3_3333, 4'hF);
        run_beats(4);
        vectors++; if (b_resp[2] !== 1'b0 || b_wait[2] != EXP_WAIT) begin
            $display("FAIL wrap4_err_prev: got resp=%b wait=%0d want 0 %0d", b_resp[2], b_wait[2], EXP_WAIT);
            miscompares++;
        end
        vectors++; if (b_wait[3] != 1 || b_resp_lo[3] !== 1'b1 || b_resp[3] !== 1'b1) begin
            $display("FAIL wrap4_err: got low=%0d resp_lo=%b resp=%b want 1 1 1", b_wait[3], b_resp_lo[3], b_resp[3]);
            miscompares++;
        end
        set_beat(0, 32'h40, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        set_beat(1, 32'h30, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(2);
        vectors++; if (b_rdata[0] !== 32'h0 || b_rdata[1] !== 32'hB2B2_2222) begin
            $display("FAIL wrap4_err_mem: got %h %h want 00000000 b2b22222", b_rdata[0], b_rdata[1]);
            miscompares++;
        end
    endtask

    task automatic test_illegal();
        logic [31:0] offs [4];
        logic [2:0]  szs  [4];
        offs[0] = 32'h100; offs[1] = 32'hFFFF_FFFC; offs[2] = 32'h16; offs[3] = 32'h18;
        szs[0] = 3'd2; szs[1] = 3'd2; szs[2] = 3'd2; szs[3] = 3'd3;
        for (int i = 0; i < 4; i++) begin
            set_beat(0, offs[i], NS, 1'b1, szs[i], 3'd0, 32'hBAD0_0000 | 32'(i + 1), 4'hF);
            run_beats(1);
            vectors++; if (b_wait[0] != 1 || b_resp_lo[0] !== 1'b1 || b_resp[0] !== 1'b1) begin
                $display("FAIL illegal%0d: got low=%0d resp_lo=%b resp=%b want 1 1 1", i, b_wait[0], b_resp_lo[0], b_resp[0]);
                miscompares++;
            end
        end
        set_beat(0, 32'h10, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        set_beat(1, 32'h00, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        set_beat(2, 32'h14, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        set_beat(3, 32'h18, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(4);
        vectors++; if (b_rdata[0] !== 32'hDEADABEF || b_resp[0] !== 1'b0) begin
            $display("FAIL after_err_read: got rdata=%h resp=%b want deadabef 0", b_rdata[0], b_resp[0]);
            miscompares++;
        end
        vectors++; if (b_rdata[1] !== 32'h0 || b_rdata[2] !== 32'h0 || b_rdata[3] !== 32'h0) begin
            $display("FAIL illegal_no_write: got %h %h %h want 0 0 0", b_rdata[1], b_rdata[2], b_rdata[3]);
            miscompares++;
        end
        set_beat(0, 32'h1C, NS, 1'b1, 3'd2, 3'd0, 32'h1111_0000, 4'hF);
        set_beat(1, 32'h20, SQ, 1'b1, 3'd2, 3'd1, 32'h2222_0000, 4'hF);
        run_beats(2);
        vectors++; if (b_resp[0] !== 1'b0 || b_resp_lo[1] !== 1'b1 || b_resp[1] !== 1'b1) begin
            $display("FAIL seq_after_single: got resp0=%b resp_lo1=%b resp1=%b want 0 1 1", b_resp[0], b_resp_lo[1], b_resp[1]);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        set_beat(0, 32'h24, NS, 1'b1, 3'd2, 3'd0, 32'h12345678, 4'hF);
        set_beat(1, 32'h24, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        set_beat(2, 32'h26, NS, 1'b1, 3'd1, 3'd0, 32'hCAFE_0000, 4'hC);
        set_beat(3, 32'h24, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(4);
        vectors++; if (b_rdata[1] !== 32'h12345678) begin
            $display("FAIL hazard_word: got %h want 12345678", b_rdata[1]); miscompares++;
        end
        vectors++; if (b_rdata[3] !== 32'hCAFE5678) begin
            $display("FAIL hazard_half: got %h want cafe5678", b_rdata[3]); miscompares++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (b_wait[i] != EXP_WAIT || b_resp[i] !== 1'b0) begin
                $display("FAIL b2b_beat%0d: got wait=%0d resp=%b want %0d 0", i, b_wait[i], b_resp[i], EXP_WAIT);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        sel = 1'b1; addr = BASE + 32'h28; trans = NS; write = 1'b1; size = 3'd2; burst = 3'd1;
        @(negedge clk);
        sel = 1'b0; trans = 2'b00; wdata = 32'h55AA55AA; strb = 4'hF;
        rstn = 1'b0;
        #1;
        vectors++; if (ready_out !== 1'b1 || resp !== 1'b0) begin
            $display("FAIL async_reset: got ready=%b resp=%b want 1 0", ready_out, resp); miscompares++;
        end
        @(negedge clk);
        rstn = 1'b1; wdata = '0; strb = '0;
        set_beat(0, 32'h28, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        set_beat(1, 32'h24, NS, 1'b0, 3'd2, 3'd0, 32'h0, 4'h0);
        run_beats(2);
        vectors++; if (b_rdata[0] !== 32'h0 || b_rdata[1] !== 32'h0) begin
            $display("FAIL reset_mid_burst: got %h %h want 0 0", b_rdata[0], b_rdata[1]); miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_byte_write();
        test_wrap4();
        test_illegal();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB slave that consumes the master-side bus signals (addr, burst, size, prot, strb, wdata, write) and returns rdata/ready/resp.
- Backs a word-addressed register array and runs the AHB address/data-phase pipeline.
- Checks burst address sequencing and answers illegal transfers with a two-cycle ERROR response.
- Sits directly downstream of the shared AHB bus interface, one instance per slave region.

Parameters:
- ADDR_WIDTH, `AHB_ADDR_WIDTH (32): address width.
- DATA_WIDTH, `AHB_DATA_WIDTH (32): data width, power of two and at least 8.
- MEM_DEPTH, 64: number of words in the array.
- BASE_ADDR, 0: byte base address of the region, word-aligned.
- WAIT_CYCLES, 2: wait states per beat; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- sel  in  1  slave select.
- addr  in  ADDR_WIDTH  byte address, address phase.
- trans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- write  in  1  1 = write.
- size  in  3  log2 of bytes per beat.
- burst  in  3  burst type.
- prot  in  4  protection; accepted and ignored.
- strb  in  DATA_WIDTH/8  write byte strobes, data phase.
- wdata  in  DATA_WIDTH  write data, data phase.
- ready_in  in  1  bus HREADY; an address phase is sampled only when it is high.
- rdata  out  DATA_WIDTH  read data.
- ready_out  out  1  data phase complete.
- resp  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, rstn low):
  - ready_out=1, resp=0, rdata=0, FSM in S_IDLE, burst tracker cleared.
  - Array cleared to zero.
  - Reset mid-burst or mid-ERROR aborts the transfer immediately and leaves no partial write.
- Address phase accept: sel & ready_in & trans[1] registers addr, write, size, burst.
  - IDLE/BUSY, or sel=0, produce no data phase; outputs stay OKAY with ready_out=1.
- Legality, checked at accept:
  - addr must lie in [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8).
  - 2^size must not exceed DATA_WIDTH/8.
  - addr must be aligned to 2^size.
  - For SEQ: a burst must be active, and addr must equal the expected next address.
  - Expected next address: INCR types add 2^size. WRAPn types wrap inside an n*2^size-aligned block.
  - NONSEQ starts a burst; SINGLE never leaves the burst tracker active.
- FSM states: S_IDLE, S_DATA, S_WAIT (optional feature only), S_ERR1, S_ERR2.
  - S_IDLE/S_DATA --legal accept--> S_DATA (zero-wait, ready_out=1, resp=0).
  - S_IDLE/S_DATA --illegal accept--> S_ERR1.
  - No accept --> S_IDLE.
  - S_ERR1 (ready_out=0, resp=1) --> S_ERR2 (ready_out=1, resp=1).
  - S_ERR2 accepts the next address phase like S_DATA. Any error clears the burst tracker.
- Write commit:
  - Happens at the end of the data phase.
  - Byte lane i is written iff strb[i] AND lane i lies inside the size/addr-offset window.
  - Erroring transfers never write.
- Read: rdata = mem[addr_q word index] during an OKAY read data phase, otherwise 0.
  - A read whose address phase coincides with a write data phase to the same word returns the new data (forward or order accordingly).
- Back-to-back transfers proceed with no bubble. Throughput is one beat per cycle.

Optional Feature:
- Macro: AHB_SLV_WAIT_EN.
- Defined: every legal data phase passes through S_WAIT for WAIT_CYCLES cycles with ready_out=0, resp=0, then completes with ready_out=1.
  - Write commit and rdata occur in the completing cycle.
  - WAIT_CYCLES=0 behaves as zero-wait.
- Undefined: S_WAIT and the wait counter are absent; all legal beats are zero-wait.

Decomposition:
- Package ahb_pkg:
  - trans encodings: IDLE, BUSY, NONSEQ, SEQ.
  - burst encodings: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - resp constants: OKAY=0, ERROR=1.
  - FSM state typedef.
- One combinational sub-module, ahb_burst_next_addr (addr, size, burst -> expected next address), reused by future masters.

Test Plan:
- Reset check: hold rstn low 3 cycles, then release -> ready_out=1, resp=0, rdata=0; read of BASE+0x0 returns 0.
- Single-word write/read: NONSEQ SINGLE write 0xDEADBEEF to BASE+0x10, then read it -> rdata=0xDEADBEEF, resp=0, no wait cycles.
- Byte write: size=0 write to BASE+0x11 with wdata=0x0000AB00, strb=4'hF -> word reads 0xDEADABEF.
- WRAP4 burst: word WRAP4 at BASE+0x38,0x3C,0x30,0x34 -> all OKAY.
  - Repeat with a fourth SEQ beat at 0x40 -> ERROR (ready_out 0 then 1, resp=1 both cycles), word at 0x40 unchanged.
- Out-of-range write: write to BASE+0x100 with MEM_DEPTH=64 -> two-cycle ERROR, no array change.
  - A following legal NONSEQ read completes OKAY.
- Hazard and wait states: write 0x12345678 then immediately read the same address -> 0x12345678.
  - With AHB_SLV_WAIT_EN and WAIT_CYCLES=2 -> ready_out low exactly 2 cycles per beat.
